// File: rtl/salu_seq_pkg.sv
// salu_seq shared definitions: opcodes, FSM states, flag layout.
// Imported by every salu_seq RTL file.
package salu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_NOT   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_NAND  = 4'd5;
  localparam logic [3:0] OP_NOR   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_CLEAR = 4'd9;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] mk_flags(
    input logic [7:0] r,
    input logic       c,
    input logic       v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == 8'h00);
    f[FLAG_N] = r[7];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/salu_seq_exec.sv
// salu_seq execute step: next accumulator, flags and error
// from the latched command and the ALU result.
module salu_seq_exec
  import salu_seq_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [7:0] i_acc,
  input  logic [7:0] i_data,
  input  logic [7:0] i_result,
  input  logic [3:0] i_flags,
  output logic [7:0] o_acc,
  output logic [3:0] o_flags,
  output logic       o_err
);

  logic [8:0] w_sum;
  logic [8:0] w_dif;
  logic       w_add_v;
  logic       w_sub_v;
  logic       w_logic;

  // Carry/borrow come from a private 9-bit op; the ALU supplies the value.
  assign w_sum   = {1'b0, i_acc} + {1'b0, i_data};
  assign w_dif   = {1'b0, i_acc} - {1'b0, i_data};
  assign w_add_v = (i_acc[7] == i_data[7]) && (w_sum[7] != i_acc[7]);
  assign w_sub_v = (i_acc[7] != i_data[7]) && (w_dif[7] != i_acc[7]);
  assign w_logic = !i_op[3] && (i_op[2:1] != 2'b00);

  always_comb begin
    o_acc   = i_acc;
    o_flags = i_flags;
    o_err   = 1'b0;
    unique case (1'b1)
      (i_op == OP_ADD): begin
        o_acc   = i_result;
        o_flags = mk_flags(i_result, w_sum[8], w_add_v);
      end
      (i_op == OP_SUB): begin
        o_acc   = i_result;
        o_flags = mk_flags(i_result, w_dif[8], w_sub_v);
      end
      w_logic: begin
        o_acc   = i_result;
        o_flags = mk_flags(i_result, 1'b0, 1'b0);
      end
      (i_op == OP_LOAD): begin
        o_acc   = i_data;
        o_flags = mk_flags(i_data, 1'b0, 1'b0);
      end
      (i_op == OP_CLEAR): begin
        o_acc   = 8'h00;
        o_flags = mk_flags(8'h00, 1'b0, 1'b0);
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/salu_seq.sv
// salu_seq: accumulator sequencer driving an external 8-bit ALU.
// IDLE -> EXEC -> RESP, one command per three cycles at best.
module salu_seq
  import salu_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_code,
  input  logic [7:0]       cmd_data,
  output logic [7:0]       operanda,
  output logic [7:0]       operandb,
  output logic [2:0]       mux,
  input  logic [7:0]       result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  logic [7:0]       r_acc;
  logic [7:0]       r_data_q;
  logic [3:0]       r_op_q;
  logic [3:0]       r_flags;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_ready;
  logic             r_rsp_valid;

  logic [7:0]       w_acc;
  logic [3:0]       w_flags;
  logic             w_err;

  salu_seq_exec u_exec (
    .i_op     (r_op_q),
    .i_acc    (r_acc),
    .i_data   (r_data_q),
    .i_result (result),
    .i_flags  (r_flags),
    .o_acc    (w_acc),
    .o_flags  (w_flags),
    .o_err    (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_data_q    <= '0;
      r_op_q      <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op_q      <= cmd_code;
            r_data_q    <= cmd_data;
            r_cmd_ready <= 1'b0;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_acc       <= w_acc;
          r_flags     <= w_flags;
          r_err       <= w_err;
          if (r_cnt != '1)
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign operanda  = r_acc;
  assign operandb  = r_data_q;
  assign mux       = r_op_q[2:0];
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_acc;
  assign rsp_flags = r_flags;
  assign rsp_err   = r_err;
  assign op_count  = r_cnt;

endmodule

// File: doc/salu_seq.md
# salu_seq

Accumulator sequencer sitting directly upstream of the 8-bit `salu` combinational ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU operands and op-select from registers. It captures the ALU result into an accumulator with status flags and returns it over a second valid/ready handshake. It turns the bare ALU into a usable execution unit for the datapath.

## Interface
- `CNT_W`, default 16: width of the executed-command counter.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_code`  in  4  0–7 = ALU op (ADD, SUB, NOT, AND, OR, NAND, NOR, XOR); 8 = LOAD; 9 = CLEAR; 10–15 illegal.
- `cmd_data`  in  8  operand B, or load value.
- `operanda`  out  8  to ALU: accumulator.
- `operandb`  out  8  to ALU: registered `cmd_data`.
- `mux`  out  3  to ALU: registered `cmd_code[2:0]`.
- `result`  in  8  from ALU.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  8  accumulator after the command.
- `rsp_flags`  out  4  {z, n, c, v}.
- `rsp_err`  out  1  illegal code.
- `op_count`  out  CNT_W  commands completed, saturating.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch code and data into `op_q`/`data_q`, then go to EXEC.
- EXEC (exactly one cycle): `operanda`=acc, `operandb`=`data_q`, `mux`=`op_q[2:0]` are already stable from registers. At the closing edge:
  - Codes 0–7: acc←`result`.
    - z = (result==0); n = result[7].
    - ADD: c = carry out of 9-bit a+b; v = signed overflow.
    - SUB: c = borrow (a<b unsigned); v = signed overflow.
    - Logic ops: c and v cleared.
  - LOAD: acc←`data_q`; z/n from the new acc; c=v=0.
  - CLEAR: acc←0; z=1; n=c=v=0.
  - 10–15: acc and flags unchanged; `rsp_err`=1.
  - `op_count` increments for every code, saturating at all-ones.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data`/`rsp_flags`/`rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE and clear `rsp_err`.
- ALU drive registers hold their last values outside EXEC. The ALU output is sampled only at the EXEC closing edge.
- ALU flag computation uses an internal 9-bit add/sub on acc and `data_q`; the ALU result itself supplies the stored value.

## Timing
- Reset values:
  - State IDLE; acc, `data_q`, `op_q` = 0.
  - `operanda`/`operandb`/`mux` = 0.
  - Flags 0000; `rsp_valid`=0; `rsp_err`=0; `op_count`=0.
  - `cmd_ready`=1 once reset is released.
- Accept at edge t means: `rsp_valid` rises after edge t+1 and the response is visible in cycle t+1.
- Earliest response handshake is edge t+2; `cmd_ready` is high again in cycle t+2 and the next accept is at edge t+3. Maximum throughput is one command per 3 cycles.
- `cmd_ready` is low in EXEC and RESP. A `cmd_valid` there is ignored and must be held by the source.
- Backpressure: `rsp_valid` and the response payload stay constant for any number of cycles while `rsp_ready`=0.
- `rsp_ready` asserted outside RESP has no effect.
- Asynchronous reset in any state returns immediately to reset values. In-flight commands and pending responses are discarded.
- Arithmetic wraps modulo 256 (0xFF+0x01 → 0x00, c=1).

## Structure
- Shared package holds:
  - Opcode constants OP_ADD..OP_XOR (0–7), OP_LOAD=8, OP_CLEAR=9.
  - FSM state encoding.
  - Flag bit positions Z=3, N=2, C=1, V=0.
- `salu` is the natural sub-module. Instantiate it inside a wrapper testbench harness, not inside `salu_seq`; `salu_seq` stays ALU-agnostic at its ports.

## Test plan
- LOAD 0x7F, then ADD 0x01 → `rsp_data`=0x80, flags z0 n1 c0 v1; `op_count`=2.
- LOAD 0x05, SUB 0x05 → 0x00, z1 n0 c0 v0. Then SUB 0x06 → 0xFA, z0 n1 c1 v0.
- LOAD 0xFF, ADD 0x01 → 0x00, z1 c1 v0. Then NOT (data ignored) → 0xFF, n1 c0 v0.
- Hold `rsp_ready`=0 for 5 cycles after a response → `rsp_valid` and payload stable, `cmd_ready`=0 throughout. Release → IDLE the next cycle.
- `cmd_code`=12 with acc=0x3C → `rsp_err`=1, `rsp_data`=0x3C, flags unchanged, `op_count` increments.
- Assert `rst_n`=0 during RESP → `rsp_valid`=0 and acc=0 immediately (asynchronous), `op_count`=0. Then CLEAR → z=1.
